// File: rtl/strait_pkg.sv
// Shared types and codes for the STRAIT self-test sequencer.
package strait_pkg;

  typedef enum logic [3:0] {
    IDLE,
    MBIST,
    SA_LOAD,
    SA_CAPTURE,
    SA_CHECK,
    TD_LOAD,
    TD_LAUNCH,
    TD_CAPTURE,
    TD_CHECK,
    DIAG,
    REPAIR,
    DONE
  } strait_state_t;

  localparam logic [2:0] STATUS_IDLE         = 3'd0;
  localparam logic [2:0] STATUS_RUNNING      = 3'd1;
  localparam logic [2:0] STATUS_PASS         = 3'd2;
  localparam logic [2:0] STATUS_REPAIRED     = 3'd3;
  localparam logic [2:0] STATUS_UNREPAIRABLE = 3'd4;
  localparam logic [2:0] STATUS_MBIST_FAIL   = 3'd5;
  localparam logic [2:0] STATUS_TIMEOUT      = 3'd6;
  localparam logic [2:0] STATUS_ABORTED      = 3'd7;

  localparam logic [1:0] RUN_MODE_FULL         = 2'b00;
  localparam logic [1:0] RUN_MODE_MBIST        = 2'b01;
  localparam logic [1:0] RUN_MODE_LBIST        = 2'b10;
  localparam logic [1:0] RUN_MODE_LBIST_REPAIR = 2'b11;

  // States that wait on an external handshake and are guarded by the watchdog.
  function automatic logic is_wait_state(input strait_state_t s);
    return (s == MBIST) || (s == SA_CHECK) || (s == TD_CHECK) ||
           (s == DIAG)  || (s == REPAIR);
  endfunction

endpackage

// File: rtl/strait_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CYCLES-th enabled cycle is reached.
module strait_watchdog
  import strait_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    expired = enable && (cnt == LAST);
  end

endmodule

// File: rtl/strait_self_test_ctrl.sv
// STRAIT self-test / self-recovery sequencer: MBIST, LBIST SA and TD sweeps,
// DLC diagnosis and BISR repair, with registered state-decoded outputs.
module strait_self_test_ctrl
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE          = 8,
  parameter int SA_TEST_PATTERN_DEPTH  = 12,
  parameter int TD_TEST_PATTERN_DEPTH  = 16,
  parameter int TD_PE_GROUPS           = 4,
  parameter int CAPTURE_CYCLES         = 2 * SYSTOLIC_SIZE,
  parameter int TIMEOUT_CYCLES         = 1024,
  parameter int FAIL_CNT_WIDTH         = 8,
  parameter int MAX_PATTERN_ADDR_WIDTH = $clog2(TD_TEST_PATTERN_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [1:0]                          run_mode,
  input  logic                                mbist_done,
  input  logic                                mbist_fail,
  input  logic                                compare_valid,
  input  logic                                pattern_mismatch,
  input  logic                                dlc_done,
  input  logic                                recovery_done,
  input  logic                                recovery_success,
  output logic                                busy,
  output logic                                test_mode,
  output logic                                bist_mode,
  output logic                                mbist_start,
  output logic                                test_type,
  output logic [MAX_PATTERN_ADDR_WIDTH-1:0]   test_counter,
  output logic [$clog2(TD_PE_GROUPS)-1:0]     td_pe_select,
  output logic                                scan_en,
  output logic                                acc_wr_en,
  output logic                                dlc_start,
  output logic                                envm_wr_en,
  output logic                                weight_start,
  output logic                                done,
  output logic [2:0]                          status,
  output logic [FAIL_CNT_WIDTH-1:0]           fail_count
);

  localparam int PW     = MAX_PATTERN_ADDR_WIDTH;
  localparam int GW     = $clog2(TD_PE_GROUPS);
  localparam int PH_MAX = (CAPTURE_CYCLES > SYSTOLIC_SIZE) ? CAPTURE_CYCLES : SYSTOLIC_SIZE;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] LOAD_LAST = PH_W'(SYSTOLIC_SIZE - 1);
  localparam logic [PH_W-1:0] CAP_LAST  = PH_W'(CAPTURE_CYCLES - 1);
  localparam logic [PW-1:0]   SA_LAST   = PW'(SA_TEST_PATTERN_DEPTH - 1);
  localparam logic [PW-1:0]   TD_LAST   = PW'(TD_TEST_PATTERN_DEPTH - 1);
  localparam logic [GW-1:0]   GRP_LAST  = GW'(TD_PE_GROUPS - 1);

  strait_state_t              state_q, state_d;
  logic [PH_W-1:0]            phase_q, phase_d;
  logic [PW-1:0]              tc_d;
  logic [GW-1:0]              grp_d;
  logic                       tt_d;
  logic [FAIL_CNT_WIDTH-1:0]  fc_d, fc_upd;
  logic [2:0]                 status_d;
  logic                       wd_expired;
  logic                       repair_en;
  logic                       busy_state;

  strait_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .enable  (is_wait_state(state_q)),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tc_d       = test_counter;
    grp_d      = td_pe_select;
    tt_d       = test_type;
    fc_d       = fail_count;
    status_d   = status;
    busy_state = (state_q != IDLE) && (state_q != DONE);
    repair_en  = (run_mode == RUN_MODE_FULL) || (run_mode == RUN_MODE_LBIST_REPAIR);
    if (pattern_mismatch && (fail_count != '1)) begin
      fc_upd = fail_count + 1'b1;
    end else begin
      fc_upd = fail_count;
    end

    if (abort && busy_state) begin
      state_d  = DONE;
      status_d = STATUS_ABORTED;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = run_mode[1] ? SA_LOAD : MBIST;
            phase_d  = '0;
            tc_d     = '0;
            grp_d    = '0;
            tt_d     = 1'b0;
            fc_d     = '0;
            status_d = STATUS_RUNNING;
          end
        end
        MBIST: begin
          if (mbist_done) begin
            if (mbist_fail) begin
              state_d  = DONE;
              status_d = STATUS_MBIST_FAIL;
            end else if (run_mode == RUN_MODE_MBIST) begin
              state_d  = DONE;
              status_d = STATUS_PASS;
            end else begin
              state_d = SA_LOAD;
              phase_d = '0;
            end
          end else if (wd_expired) begin
            state_d  = DONE;
            status_d = STATUS_TIMEOUT;
          end
        end
        SA_LOAD, TD_LOAD: begin
          if (phase_q == LOAD_LAST) begin
            phase_d = '0;
            state_d = (state_q == SA_LOAD) ? SA_CAPTURE : TD_LAUNCH;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        TD_LAUNCH: begin
          state_d = TD_CAPTURE;
        end
        SA_CAPTURE, TD_CAPTURE: begin
          if (phase_q == CAP_LAST) begin
            phase_d = '0;
            state_d = (state_q == SA_CAPTURE) ? SA_CHECK : TD_CHECK;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        // A compare in the expiry cycle is still taken: handshake before watchdog.
        SA_CHECK: begin
          if (compare_valid) begin
            fc_d = fc_upd;
            if (test_counter == SA_LAST) begin
              tc_d    = '0;
              tt_d    = 1'b1;
              state_d = TD_LOAD;
            end else begin
              tc_d    = test_counter + 1'b1;
              state_d = SA_LOAD;
            end
          end else if (wd_expired) begin
            state_d  = DONE;
            status_d = STATUS_TIMEOUT;
          end
        end
        // Counters stay on the last pattern/group so DONE shows where the sweep ended.
        TD_CHECK: begin
          if (compare_valid) begin
            fc_d = fc_upd;
            if (td_pe_select != GRP_LAST) begin
              grp_d   = td_pe_select + 1'b1;
              state_d = TD_LOAD;
            end else if (test_counter != TD_LAST) begin
              grp_d   = '0;
              tc_d    = test_counter + 1'b1;
              state_d = TD_LOAD;
            end else if (fc_upd == '0) begin
              state_d  = DONE;
              status_d = STATUS_PASS;
            end else begin
              state_d = DIAG;
            end
          end else if (wd_expired) begin
            state_d  = DONE;
            status_d = STATUS_TIMEOUT;
          end
        end
        DIAG: begin
          if (dlc_done) begin
            if (repair_en) begin
              state_d = REPAIR;
            end else begin
              state_d  = DONE;
              status_d = STATUS_UNREPAIRABLE;
            end
          end else if (wd_expired) begin
            state_d  = DONE;
            status_d = STATUS_TIMEOUT;
          end
        end
        REPAIR: begin
          if (recovery_done) begin
            state_d  = DONE;
            status_d = recovery_success ? STATUS_REPAIRED : STATUS_UNREPAIRABLE;
          end else if (wd_expired) begin
            state_d  = DONE;
            status_d = STATUS_TIMEOUT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      test_counter <= '0;
      td_pe_select <= '0;
      test_type    <= 1'b0;
      fail_count   <= '0;
      status       <= STATUS_IDLE;
      busy         <= 1'b0;
      test_mode    <= 1'b0;
      bist_mode    <= 1'b0;
      mbist_start  <= 1'b0;
      scan_en      <= 1'b0;
      acc_wr_en    <= 1'b0;
      dlc_start    <= 1'b0;
      envm_wr_en   <= 1'b0;
      weight_start <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      test_counter <= tc_d;
      td_pe_select <= grp_d;
      test_type    <= tt_d;
      fail_count   <= fc_d;
      status       <= status_d;
      busy         <= (state_d != IDLE) && (state_d != DONE);
      test_mode    <= (state_d != IDLE) && (state_d != DONE) && (state_d != REPAIR);
      bist_mode    <= (state_d != IDLE) && (state_d != DONE) && (state_d != REPAIR) &&
                      (state_d != MBIST);
      mbist_start  <= (state_d == MBIST) && (state_q != MBIST);
      scan_en      <= (state_d == SA_LOAD) || (state_d == TD_LOAD);
      acc_wr_en    <= (state_d == SA_CAPTURE) || (state_d == TD_CAPTURE);
      dlc_start    <= (state_d == DIAG) && (state_q != DIAG);
      envm_wr_en   <= (state_d == DIAG);
      weight_start <= (state_d == REPAIR) && (state_q != REPAIR);
      done         <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_strait_self_test_ctrl.sv
// Directed self-checking bench for strait_self_test_ctrl.
module tb_strait_self_test_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [1:0] run_mode;
  logic       mbist_done, mbist_fail, compare_valid, pattern_mismatch;
  logic       dlc_done, recovery_done, recovery_success;
  logic       busy, test_mode, bist_mode, mbist_start, test_type;
  logic [3:0] test_counter;
  logic [1:0] td_pe_select;
  logic       scan_en, acc_wr_en, dlc_start, envm_wr_en, weight_start, done;
  logic [2:0] status;
  logic [7:0] fail_count;

  int errors = 0;
  int checks = 0;
  int bad_idx = 0;
  int bad_len = 0;
  int scan_cycles = 0;
  int mbist_pulses = 0;

  always #5 clk = ~clk;

  strait_self_test_ctrl #(
    .SYSTOLIC_SIZE         (8),
    .SA_TEST_PATTERN_DEPTH (12),
    .TD_TEST_PATTERN_DEPTH (16),
    .TD_PE_GROUPS          (4),
    .CAPTURE_CYCLES        (16),
    .TIMEOUT_CYCLES        (1024),
    .FAIL_CNT_WIDTH        (8),
    .MAX_PATTERN_ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .run_mode(run_mode),
    .mbist_done(mbist_done), .mbist_fail(mbist_fail),
    .compare_valid(compare_valid), .pattern_mismatch(pattern_mismatch),
    .dlc_done(dlc_done), .recovery_done(recovery_done), .recovery_success(recovery_success),
    .busy(busy), .test_mode(test_mode), .bist_mode(bist_mode), .mbist_start(mbist_start),
    .test_type(test_type), .test_counter(test_counter), .td_pe_select(td_pe_select),
    .scan_en(scan_en), .acc_wr_en(acc_wr_en), .dlc_start(dlc_start), .envm_wr_en(envm_wr_en),
    .weight_start(weight_start), .done(done), .status(status), .fail_count(fail_count)
  );

  always @(negedge clk) begin
    if (scan_en === 1'b1) scan_cycles++;
    if (mbist_start === 1'b1) mbist_pulses++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bound(input string tag, input int n, input int lim);
    checks++;
    assert (n < lim) else begin
      errors++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, lim);
    end
  endtask

  task automatic pulse_start(input logic [1:0] mode);
    run_mode = mode;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One LBIST pattern: p 0..11 are SA patterns, 12..75 are TD (pattern, group).
  task automatic run_pattern(input int p, input bit mis, input bit respond);
    int n, slen, clen, gap, exp_tc, exp_grp;
    n = 0;
    while (scan_en !== 1'b1 && n < 64) begin step(); n++; end
    chk_bound("scan_wait", n, 64);
    exp_tc  = (p < 12) ? p : (p - 12) / 4;
    exp_grp = (p < 12) ? 0 : (p - 12) % 4;
    if (test_counter !== 4'(exp_tc) || td_pe_select !== 2'(exp_grp) ||
        test_type !== (p >= 12)) bad_idx++;
    slen = 0;
    while (scan_en === 1'b1 && slen < 64) begin slen++; step(); end
    gap = 0;
    while (acc_wr_en !== 1'b1 && gap < 64) begin gap++; step(); end
    clen = 0;
    while (acc_wr_en === 1'b1 && clen < 64) begin clen++; step(); end
    if (slen != 8 || clen != 16 || gap != ((p >= 12) ? 1 : 0)) bad_len++;
    if (respond) begin
      compare_valid = 1'b1;
      pattern_mismatch = mis;
      step();
      compare_valid = 1'b0;
      pattern_mismatch = 1'b0;
    end
  endtask

  task automatic run_lbist(input int npat, input int mis_a, input int mis_b);
    for (int p = 0; p < npat; p++) run_pattern(p, (p == mis_a) || (p == mis_b), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, sc0, mb0;
    rst = 1'b1; start = 0; abort = 0; run_mode = 2'b00;
    mbist_done = 0; mbist_fail = 0; compare_valid = 0; pattern_mismatch = 0;
    dlc_done = 0; recovery_done = 0; recovery_success = 0;
    repeat (2) step();
    chk("reset_status", status, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    step();
    chk("idle_status", status, 0);
    chk("idle_fail_count", fail_count, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_in_idle_ignored", done, 0);

    // 1: MBIST only
    sc0 = scan_cycles;
    pulse_start(2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_status_running", status, 1);
    chk("t1_mbist_start", mbist_start, 1);
    chk("t1_test_mode", test_mode, 1);
    chk("t1_bist_mode", bist_mode, 0);
    step();
    chk("t1_mbist_start_pulse", mbist_start, 0);
    repeat (48) step();
    mbist_done = 1'b1; step(); mbist_done = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_status", status, 2);
    chk("t1_busy_low", busy, 0);
    chk("t1_no_scan", scan_cycles - sc0, 0);

    // 2: LBIST only, clean
    sc0 = scan_cycles; mb0 = mbist_pulses;
    pulse_start(2'b10);
    chk("t2_scan_first", scan_en, 1);
    chk("t2_done_dropped", done, 0);
    chk("t2_bist_mode", bist_mode, 1);
    run_lbist(76, -1, -1);
    chk("t2_done", done, 1);
    chk("t2_status", status, 2);
    chk("t2_fail_count", fail_count, 0);
    chk("t2_scan_cycles", scan_cycles - sc0, 76 * 8);
    chk("t2_no_mbist", mbist_pulses - mb0, 0);
    chk("t2_pattern_index", bad_idx, 0);
    chk("t2_pattern_timing", bad_len, 0);

    // 3: LBIST + repair with two mismatches
    pulse_start(2'b11);
    chk("t3_fail_count_cleared", fail_count, 0);
    run_lbist(76, 3, 12 + 7 * 4 + 2);
    chk("t3_fail_count", fail_count, 2);
    chk("t3_dlc_start", dlc_start, 1);
    chk("t3_envm_wr_en", envm_wr_en, 1);
    chk("t3_test_mode_diag", test_mode, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("t3_dlc_start_pulse", dlc_start, 0);
    chk("t3_start_ignored", status, 1);
    chk("t3_envm_held", envm_wr_en, 1);
    repeat (3) step();
    dlc_done = 1'b1; step(); dlc_done = 1'b0;
    chk("t3_weight_start", weight_start, 1);
    chk("t3_test_mode_repair", test_mode, 0);
    chk("t3_envm_off", envm_wr_en, 0);
    repeat (4) step();
    recovery_done = 1'b1; recovery_success = 1'b1; step();
    recovery_done = 1'b0; recovery_success = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_status", status, 3);

    // 4: full flow, MBIST fails
    sc0 = scan_cycles;
    pulse_start(2'b00);
    chk("t4_mbist_start", mbist_start, 1);
    chk("t4_test_type_cleared", test_type, 0);
    repeat (10) step();
    mbist_done = 1'b1; mbist_fail = 1'b1; step();
    mbist_done = 1'b0; mbist_fail = 1'b0;
    chk("t4_status", status, 5);
    chk("t4_done", done, 1);
    chk("t4_test_type", test_type, 0);
    chk("t4_no_scan", scan_cycles - sc0, 0);

    // 5: withheld compare -> watchdog
    pulse_start(2'b10);
    run_pattern(0, 1'b0, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin step(); n++; end
    chk("t5_timeout_cycles", n, 1024);
    chk("t5_status", status, 6);
    pulse_start(2'b10);
    chk("t5_rerun_status", status, 1);
    chk("t5_rerun_counter", test_counter, 0);
    run_lbist(76, -1, -1);
    chk("t5_rerun_pass", status, 2);
    chk("t5_rerun_index", bad_idx, 0);
    chk("t5_rerun_timing", bad_len, 0);

    // 6: abort during TD capture, then reset mid-run
    pulse_start(2'b10);
    run_lbist(12, -1, -1);
    n = 0;
    while (acc_wr_en !== 1'b1 && n < 64) begin step(); n++; end
    chk_bound("t6_capture_wait", n, 64);
    chk("t6_in_td", test_type, 1);
    repeat (2) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_status", status, 7);
    chk("t6_acc_wr_en", acc_wr_en, 0);
    chk("t6_busy", busy, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t6_abort_in_done_ignored", status, 7);
    pulse_start(2'b01);
    repeat (5) step();
    chk("t6_running_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_test_mode", test_mode, 0);
    chk("t6_rst_status", status, 0);
    chk("t6_rst_done", done, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_idle_after_rst", status, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
